// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-access encodings for the load and store paths
package mem_pkg;

  // Access size as driven by the control unit (SB/SH/SW and LB/LH/LW)
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Error codes reported alongside an aborted store
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Store formatter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - replicates store data onto byte lanes and builds byte enables
module store_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  // Lane replication: the memory picks the right lane via be, so every lane carries the value
  always_comb begin
    wdata      = 32'h0;
    be         = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        wdata      = data;
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        wdata = 32'h0;
        be    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/store_lane_formatter.sv
// rtl/store_lane_formatter.sv - formats a store and runs one req/ack memory write with timeout
module store_lane_formatter
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err,
  output logic [1:0]        st_err_code
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  st_state_e         state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [1:0]        err_q, err_nx;
  logic [DATA_W-1:0] fmt_wdata;
  logic [3:0]        fmt_be;
  logic              fmt_misal;
  logic              timeout_hit;

  store_lane_align u_align (
    .size       (st_size),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (fmt_wdata),
    .be         (fmt_be),
    .misaligned (fmt_misal)
  );

  // Last no-ack cycle of REQ: counter already shows ACK_TIMEOUT-1 completed waits
  assign timeout_hit = (cnt == CNT_W'(ACK_TIMEOUT - 1));

  // Next-state: reserved size outranks misalignment; ack outranks timeout
  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (st_valid) begin
          if (st_size == SZ_RSVD) begin
            state_nx = ERR;
            err_nx   = ERR_SIZE;
          end else if (fmt_misal) begin
            state_nx = ERR;
            err_nx   = ERR_MISALIGN;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_nx = DONE;
        end else if (timeout_hit) begin
          state_nx = ERR;
          err_nx   = ERR_TIMEOUT;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, wait counter and the transaction registers held stable through REQ
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
      err_q   <= ERR_NONE;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (state == REQ && state_nx == REQ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == IDLE && st_valid) begin
        addr_q  <= {st_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= fmt_wdata;
        be_q    <= fmt_be;
      end
    end
  end

  assign st_ready    = (state == IDLE);
  assign mem_req     = (state == REQ);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = (state == REQ) ? be_q : 4'b0000;
  assign st_done     = (state == DONE);
  assign st_err      = (state == ERR);
  assign st_err_code = (state == ERR) ? err_q : ERR_NONE;

endmodule

// File: tb/tb_store_lane_formatter.sv
// tb/tb_store_lane_formatter.sv - self-checking bench for store_lane_formatter
module tb_store_lane_formatter;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        st_done;
  logic        st_err;
  logic [1:0]  st_err_code;

  int n_chk;
  int n_fail;

  store_lane_formatter #(.DATA_W(32), .ADDR_W(32), .ACK_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .st_done     (st_done),
    .st_err      (st_err),
    .st_err_code (st_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_dly;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    bit          e_done;
    logic [1:0]  e_code;
    int          e_req;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: result of one store from the architectural rules
  function automatic vec_t model(input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] d, input int dly);
    vec_t v;
    int   off;
    off       = int'(a % 4);
    v.size    = sz;
    v.addr    = a;
    v.data    = d;
    v.ack_dly = dly;
    v.e_addr  = a - (a % 4);
    v.e_wdata = 32'h0;
    v.e_be    = 4'h0;
    v.e_done  = 1'b0;
    v.e_code  = 2'd0;
    v.e_req   = 0;
    if (sz == 2'd3) begin
      v.e_code = 2'd3;
    end else if ((sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0)) begin
      v.e_code = 2'd1;
    end else begin
      if (sz == 2'd0) begin
        v.e_wdata = (d % 256) * 32'h0101_0101;
        v.e_be    = 4'(1 << off);
      end else if (sz == 2'd1) begin
        v.e_wdata = (d % 65536) * 32'h0001_0001;
        v.e_be    = (off >= 2) ? 4'hC : 4'h3;
      end else begin
        v.e_wdata = d;
        v.e_be    = 4'hF;
      end
      if (dly < 15) begin
        v.e_done = 1'b1;
        v.e_req  = dly + 1;
      end else begin
        v.e_code = 2'd2;
        v.e_req  = 15;
      end
    end
    return v;
  endfunction

  // Issue one store, ack on request cycle ack_dly+1, and check everything observed
  task automatic run_vec(input string tag, input vec_t v);
    int          cyc;
    int          req_cnt;
    int          res_cyc;
    bit          got;
    bit          got_done;
    logic [1:0]  got_code;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_be;
    bit          unstable, stray, ready_bad;
    cyc = 0; req_cnt = 0; res_cyc = 0; got = 0; got_done = 0; got_code = 2'd0;
    f_addr = 32'h0; f_wdata = 32'h0; f_be = 4'h0;
    unstable = 0; stray = 0; ready_bad = 0;
    @(negedge clk);
    check({tag, " ready_before"}, {31'd0, st_ready}, 32'd1);
    st_valid = 1'b1;
    st_size  = v.size;
    st_addr  = v.addr;
    st_data  = v.data;
    while (!got && cyc < 40) begin
      @(negedge clk);
      st_valid = 1'b0;
      mem_ack  = 1'b0;
      cyc++;
      if (st_ready) ready_bad = 1;
      if (!mem_req && mem_be != 4'h0) stray = 1;
      if (!st_err && st_err_code != 2'd0) stray = 1;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be;
        end else if (mem_addr !== f_addr || mem_wdata !== f_wdata || mem_be !== f_be) begin
          unstable = 1;
        end
        if (req_cnt == v.ack_dly + 1) mem_ack = 1'b1;
      end
      if (st_done || st_err) begin
        got      = 1;
        got_done = st_done;
        got_code = st_err_code;
        res_cyc  = cyc;
      end
    end
    mem_ack = 1'b0;
    check({tag, " finished"}, {31'd0, got}, 32'd1);
    check({tag, " done"}, {31'd0, got_done}, {31'd0, v.e_done});
    check({tag, " err_code"}, {30'd0, got_code}, {30'd0, v.e_code});
    check({tag, " req_cycles"}, req_cnt, v.e_req);
    check({tag, " result_cycle"}, res_cyc, v.e_req + 1);
    check({tag, " no_stray_be_or_code"}, {31'd0, stray}, 32'd0);
    check({tag, " ready_low_busy"}, {31'd0, ready_bad}, 32'd0);
    if (v.e_req > 0) begin
      check({tag, " mem_addr"}, f_addr, v.e_addr);
      check({tag, " mem_wdata"}, f_wdata, v.e_wdata);
      check({tag, " mem_be"}, {28'd0, f_be}, {28'd0, v.e_be});
      check({tag, " stable"}, {31'd0, unstable}, 32'd0);
    end
    @(negedge clk);
    check({tag, " pulse_one_cycle"}, {30'd0, st_done, st_err}, 32'd0);
    check({tag, " ready_after"}, {31'd0, st_ready}, 32'd1);
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; st_valid = 1'b0; st_size = 2'd0; st_addr = 32'h0; st_data = 32'h0; mem_ack = 1'b0;

    //          size   addr          data          dly  e_addr        e_wdata       be    done code req
    vecs.push_back('{2'd0, 32'h0000_1003, 32'h1234_56AB, 2,  32'h0000_1000, 32'hABAB_ABAB, 4'h8, 1'b1, 2'd0, 3});
    vecs.push_back('{2'd1, 32'h0000_2002, 32'hFFFF_8001, 0,  32'h0000_2000, 32'h8001_8001, 4'hC, 1'b1, 2'd0, 1});
    vecs.push_back('{2'd2, 32'h0000_3006, 32'h1111_2222, 0,  32'h0,         32'h0,         4'h0, 1'b0, 2'd1, 0});
    vecs.push_back('{2'd1, 32'h0000_3001, 32'h1111_2222, 0,  32'h0,         32'h0,         4'h0, 1'b0, 2'd1, 0});
    vecs.push_back('{2'd3, 32'h0000_5000, 32'h5555_5555, 0,  32'h0,         32'h0,         4'h0, 1'b0, 2'd3, 0});
    vecs.push_back('{2'd3, 32'h0000_5001, 32'h5555_5555, 0,  32'h0,         32'h0,         4'h0, 1'b0, 2'd3, 0});
    vecs.push_back('{2'd2, 32'h0000_4000, 32'hDEAD_BEEF, 99, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 1'b0, 2'd2, 15});
    vecs.push_back('{2'd2, 32'h0000_4000, 32'h0BAD_F00D, 14, 32'h0000_4000, 32'h0BAD_F00D, 4'hF, 1'b1, 2'd0, 15});
    vecs.push_back('{2'd0, 32'h0000_0010, 32'h0000_0077, 1,  32'h0000_0010, 32'h7777_7777, 4'h1, 1'b1, 2'd0, 2});
    vecs.push_back('{2'd1, 32'h0000_0020, 32'h1234_ABCD, 0,  32'h0000_0020, 32'hABCD_ABCD, 4'h3, 1'b1, 2'd0, 1});
    vecs.push_back('{2'd0, 32'h0000_7FFE, 32'h0000_00C3, 5,  32'h0000_7FFC, 32'hC3C3_C3C3, 4'h4, 1'b1, 2'd0, 6});

    repeat (2) @(negedge clk);
    check("reset ready", {31'd0, st_ready}, 32'd1);
    check("reset req_be", {27'd0, mem_req, mem_be}, 32'd0);
    check("reset addr", mem_addr, 32'd0);
    check("reset wdata", mem_wdata, 32'd0);
    check("reset flags", {28'd0, st_done, st_err, st_err_code}, 32'd0);
    rst_n = 1'b1;

    // Acks while idle must not produce anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle ack ignored", {29'd0, mem_req, st_done, st_err}, 32'd0);

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    for (int k = 0; k < 40; k++) begin
      rv = model(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 17));
      run_vec($sformatf("rnd%0d", k), rv);
    end

    // Reset in the middle of REQ, then a late ack must be ignored
    @(negedge clk);
    st_valid = 1'b1; st_size = 2'd2; st_addr = 32'h0000_4000; st_data = 32'hCAFE_F00D;
    @(negedge clk);
    st_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid req asserted", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid rst req", {31'd0, mem_req}, 32'd0);
    check("mid rst ready", {31'd0, st_ready}, 32'd1);
    check("mid rst be", {28'd0, mem_be}, 32'd0);
    check("mid rst addr", mem_addr, 32'd0);
    check("mid rst wdata", mem_wdata, 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    begin
      bit seen;
      seen = 0;
      repeat (4) begin
        if (st_done || st_err || mem_req) seen = 1;
        @(negedge clk);
      end
      check("late ack ignored", {31'd0, seen}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
